norm_reduce_lanes: RTL
======================

# norm_reduce_lanes

Parametrised multi-lane reduction engine over a banked on-chip array. It is the next generation of the single-lane sum-of-squares `main` kernel. It reads `LANES` elements per cycle from an internal interleaved memory, reduces them by a selectable mode (sum of squares, sum of magnitudes, max magnitude) into a wide accumulator, and reports the result with a done strobe. It sits behind the host, which loads the array through the `controlArr` side port and can pre-empt the engine at any time.

## Interface
Parameters:
- `DATA_W`, default 27: signed element width.
- `ADDR_W`, default 10: element index width. `DEPTH = 2**ADDR_W`.
- `ACC_W`, default 64: signed accumulator width. Must satisfy `ACC_W >= 2*DATA_W + log2(LANES)`.
- `LANES`, default 4: elements read per cycle. Power of two, 1..16.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `r_enable`, in, 1: start pulse. The inputs `init_*_t_a` and `mode` are captured on this edge.
- `init_i_t_a`, in, ADDR_W: first element index (inclusive).
- `init_end_t_a`, in, ADDR_W+1: end element index (exclusive). Clamped to DEPTH.
- `init_acc_t_a`, in, ACC_W signed: initial accumulator value.
- `mode`, in, 2: reduction mode. 00 = sum of x². 01 = sum of |x|. 10 = max(acc, |x|). 11 behaves as 00.
- `controlArr`, in, 1: host owns the memory port this cycle.
- `controlArrWEnable_a`, in, 1: host write enable.
- `controlArrAddr_a`, in, ADDR_W: host element index.
- `controlArrWData_a`, in, DATA_W signed: host write data.
- `controlArrRData_a`, out, DATA_W signed: host read data, one cycle after the address. Don't-care when `controlArr` was low.
- `busy`, out, 1: engine is running.
- `w_enable`, out, 1: result valid. Held high until the next start or reset.
- `overflow`, out, 1: sticky signed-overflow flag for the current run.
- `result`, out, ACC_W signed: final accumulator value.

## Operation
- **Memory layout**
  - Element k is stored in bank `k % LANES`, row `k / LANES`.
  - Each bank is `DEPTH/LANES` deep, with one synchronous read port (data one cycle after the address) and write-first-ignored semantics.
  - Host accesses select the bank from the low bits of the index.
- **Range**
  - `first_row = init_i >> log2(LANES)`.
  - `last_row = (end-1) >> log2(LANES)`.
  - `N = last_row - first_row + 1` if `end > init_i`, else 0.
  - A lane's element is valid only if `init_i <= index < end`. Invalid lanes contribute 0 (modes 00/01) or are ignored (mode 10).
- **States**
  - IDLE: reset state.
  - ISSUE: row pointer walks `first_row` to `last_row`.
  - DRAIN: 3-stage pipeline empties.
  - DONE: `w_enable` = 1, `busy` = 0.
  - Transitions:
    - `r_enable` in any state → ISSUE, or straight to DRAIN when N = 0. `busy` goes to 1, the accumulator is loaded with `init_acc`, and `overflow` is cleared. A start during a run aborts that run.
    - ISSUE → DRAIN after the last row is issued.
    - DRAIN → DONE when the pipeline valid bits are clear.
- **Pipeline** (each stage carries a valid bit)
  - Stage 1: read data registered from the banks.
  - Stage 2: per-lane x², or sign-extended |x| (|min| = 2^(DATA_W-1)), registered.
  - Stage 3: lane adder tree plus accumulate, or lane max plus signed compare against the accumulator.
- **Host priority**
  - While `controlArr` = 1, bank addresses and write enables come from the host.
  - An engine issue in that cycle becomes a bubble: the row pointer does not advance and the stage-1 valid bit is 0.
  - Engine writes never occur.
- **Arithmetic**
  - Accumulation wraps modulo 2^ACC_W.
  - `overflow` is set when the stage-3 signed add overflows (modes 00/01). It never sets in mode 10.
  - `result` is updated from the accumulator on entry to DONE.
- **Reset**
  - `rst_n` = 0 forces IDLE, `busy` = 0, `w_enable` = 0, `overflow` = 0, `result` = 0, and clears all valid bits.
  - Memory contents are not cleared.

## Timing
- Start edge = edge 0.
- Row r issues at edge r+1 when there are no stalls. `w_enable` and `result` are first valid after edge N+3.
- Each cycle with `controlArr` high during ISSUE adds exactly one cycle. `controlArr` during DRAIN/DONE adds none.
- Throughput: one row (`LANES` elements) per cycle.
- `busy` falls on the same edge that `w_enable` rises.
- `r_enable` with `rst_n` = 0: reset wins.

## Test plan
- Sum of squares, full range:
  - Stimulus: host writes a[k] = k-500 for k = 0..1023. Start with i = 0, end = 1000, acc = 0, mode 00.
  - Response: result = 83333500, overflow = 0, `w_enable` after edge 253 (N = 250).
- Unaligned partial rows, sum of magnitudes:
  - Stimulus: a[3..5] = -2, 5, -7 and all other elements 99. Start with i = 3, end = 6, acc = 10, mode 01.
  - Response: result = 24, `w_enable` after edge 5 (N = 2).
- Max magnitude:
  - Stimulus: a[0..3] = 4, -9, 7, 0. Start with i = 0, end = 4, acc = 5, mode 10.
  - Response: result = 9. A rerun with a[1] = -2^26 gives result = 67108864.
- Overflow:
  - Stimulus: acc = 0x7FFF_FFFF_FFFF_FFFF, a[0] = 1. Start with i = 0, end = 1, mode 00.
  - Response: result = 0x8000_0000_0000_0000, overflow = 1. The next start clears overflow.
- Host stall:
  - Stimulus: repeat the full-range sum-of-squares run with `controlArr` = 1 for 5 cycles at edges 50..54, with host reads issued during those cycles.
  - Response: result = 83333500, `w_enable` after edge 258. Host read data is correct one cycle after each address.
- Reset mid-run, then empty range:
  - Stimulus: `rst_n` = 0 at edge 100 of a full-range run. Then start with i = 7, end = 7, acc = 42.
  - Response: all outputs 0 after the reset. Then result = 42 with `w_enable` after edge 3.

Source files
------------

// File: rtl/norm_reduce_lanes.sv
// norm_reduce_lanes
// Multi-lane reduction engine over a banked on-chip array. Each cycle it
// reads LANES consecutive elements (one row), turns each into x^2 or |x|,
// and folds the row into a wide signed accumulator (sum or running max).
// The host can load/read the array through the controlArr side port and
// always has priority over the engine for the bank ports.
//
// Ports
//   clk, rst_n             : clock, synchronous active-low reset
//   r_enable               : start pulse; captures init_* and mode
//   init_i_t_a             : first element index (inclusive)
//   init_end_t_a           : end element index (exclusive), clamped to DEPTH
//   init_acc_t_a           : initial accumulator value
//   mode                   : 00 sum x^2, 01 sum |x|, 10 max |x|, 11 as 00
//   controlArr             : host owns the memory ports this cycle
//   controlArrWEnable_a    : host write enable
//   controlArrAddr_a       : host element index
//   controlArrWData_a      : host write data
//   controlArrRData_a      : host read data, one cycle after the address
//   busy                   : engine running
//   w_enable               : result valid, held until next start or reset
//   overflow               : sticky signed overflow of the current run
//   result                 : final accumulator value
//
// ACC_W must be at least 2*DATA_W + log2(LANES) so a single row sum of
// squares can never look negative.
module norm_reduce_lanes #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 64,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r_enable,
  input  logic [ADDR_W-1:0]        init_i_t_a,
  input  logic [ADDR_W:0]          init_end_t_a,
  input  logic signed [ACC_W-1:0]  init_acc_t_a,
  input  logic [1:0]               mode,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic                     busy,
  output logic                     w_enable,
  output logic                     overflow,
  output logic signed [ACC_W-1:0]  result
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOG_L  = $clog2(LANES);
  localparam int ROWS   = DEPTH / LANES;
  localparam int ROW_W  = ADDR_W - LOG_L;
  localparam int BANK_W = (LOG_L > 0) ? LOG_L : 1;
  localparam int PW     = 2 * DATA_W;

  localparam logic [1:0] MODE_SQ  = 2'b00;
  localparam logic [1:0] MODE_ABS = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                   state;
  logic [ROW_W-1:0]         row_ptr;
  logic [ROW_W-1:0]         last_row_q;
  logic [ADDR_W-1:0]        start_q;
  logic [ADDR_W:0]          end_q;
  logic [1:0]               mode_q;
  logic [1:0]               drain_cnt;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] mem [LANES][ROWS];
  logic signed [DATA_W-1:0] rd_data [LANES];
  logic [BANK_W-1:0]        host_bank;
  logic [BANK_W-1:0]        host_bank_q;
  logic [ROW_W-1:0]         host_row;
  logic [ROW_W-1:0]         rd_row;

  logic                     issue;
  logic [LANES-1:0]         issue_mask;
  logic                     s1_valid, s2_valid;
  logic [LANES-1:0]         s1_mask, s2_mask;

  logic [DATA_W:0]          x_ext [LANES];
  logic [DATA_W:0]          mag [LANES];
  logic [PW-1:0]            lane_val [LANES];
  logic [PW-1:0]            s2_val [LANES];

  logic [ADDR_W:0]          end_clamp;
  logic                     empty_range;
  logic [ROW_W-1:0]         first_row;
  logic [ROW_W-1:0]         last_row;

  logic [ACC_W-1:0]         lane_sum;
  logic [PW-1:0]            lane_max;
  logic                     any_valid;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  max_ext;
  logic                     add_ovf;
  logic                     max_wins;

  // Decode the requested range at start time into a row window.
  always_comb begin
    end_clamp   = (init_end_t_a > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : init_end_t_a;
    empty_range = (end_clamp <= {1'b0, init_i_t_a});
    first_row   = ROW_W'(init_i_t_a >> LOG_L);
    last_row    = ROW_W'((end_clamp - 1'b1) >> LOG_L);
  end

  // Host owns every bank port when controlArr is high; the engine issue
  // for that cycle turns into a bubble.
  always_comb begin
    host_bank = BANK_W'(controlArrAddr_a & ADDR_W'(LANES - 1));
    host_row  = ROW_W'(controlArrAddr_a >> LOG_L);
    issue     = (state == S_ISSUE) && !controlArr;
    rd_row    = controlArr ? host_row : row_ptr;
    for (int l = 0; l < LANES; l++) begin
      issue_mask[l] = ((((ADDR_W+1)'(row_ptr) << LOG_L) + (ADDR_W+1)'(l)) >= {1'b0, start_q}) &&
                      ((((ADDR_W+1)'(row_ptr) << LOG_L) + (ADDR_W+1)'(l)) < end_q);
    end
  end

  // Banked array: one synchronous read port per bank, reads return the
  // old contents when the same row is written in the same cycle.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (controlArr && controlArrWEnable_a && host_bank == BANK_W'(l))
        mem[l][host_row] <= controlArrWData_a;
      rd_data[l] <= mem[l][rd_row];
    end
    host_bank_q <= host_bank;
  end

  assign controlArrRData_a = rd_data[host_bank_q];

  // Per-lane magnitude and square. Magnitude is taken one bit wider so
  // the most negative element maps to +2^(DATA_W-1). Out-of-range lanes
  // are forced to zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      x_ext[l]    = {rd_data[l][DATA_W-1], rd_data[l]};
      mag[l]      = x_ext[l][DATA_W] ? (~x_ext[l] + 1'b1) : x_ext[l];
      lane_val[l] = '0;
      if (s1_mask[l])
        lane_val[l] = (mode_q == MODE_SQ) ? (PW'(mag[l]) * PW'(mag[l])) : PW'(mag[l]);
    end
  end

  // Stage-2 lane registers carry data only; their valid bit lives with
  // the control state.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      s2_val[l] <= lane_val[l];
  end

  // Stage 3: lane sum and lane max. All lane values are non-negative, so
  // zero-extension into the accumulator width is exact.
  always_comb begin
    lane_sum  = '0;
    lane_max  = '0;
    any_valid = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum  = lane_sum + ACC_W'(s2_val[l]);
      any_valid = any_valid | s2_mask[l];
      if (s2_mask[l] && s2_val[l] > lane_max)
        lane_max = s2_val[l];
    end
    acc_sum  = acc + $signed(lane_sum);
    add_ovf  = (acc[ACC_W-1] == lane_sum[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    max_ext  = ACC_W'(lane_max);
    max_wins = any_valid && (max_ext > acc);
  end

  // Control FSM, pipeline valid bits and accumulator. DRAIN always lasts
  // three cycles so an empty range has the same latency as a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      w_enable   <= 1'b0;
      overflow   <= 1'b0;
      result     <= '0;
      acc        <= '0;
      row_ptr    <= '0;
      last_row_q <= '0;
      start_q    <= '0;
      end_q      <= '0;
      mode_q     <= MODE_SQ;
      drain_cnt  <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_mask    <= '0;
      s2_mask    <= '0;
    end else if (r_enable) begin
      state      <= empty_range ? S_DRAIN : S_ISSUE;
      busy       <= 1'b1;
      w_enable   <= 1'b0;
      overflow   <= 1'b0;
      acc        <= init_acc_t_a;
      row_ptr    <= first_row;
      last_row_q <= last_row;
      start_q    <= init_i_t_a;
      end_q      <= end_clamp;
      mode_q     <= (mode == 2'b11) ? MODE_SQ : mode;
      drain_cnt  <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_mask    <= '0;
      s2_mask    <= '0;
    end else begin
      s1_valid <= issue;
      s1_mask  <= issue_mask;
      s2_valid <= s1_valid;
      s2_mask  <= s1_mask;
      if (s2_valid) begin
        if (mode_q == MODE_MAX) begin
          if (max_wins)
            acc <= max_ext;
        end else begin
          acc <= acc_sum;
          if (add_ovf)
            overflow <= 1'b1;
        end
      end
      unique case (state)
        S_ISSUE: begin
          if (issue) begin
            if (row_ptr == last_row_q) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              row_ptr <= row_ptr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd2 && !s1_valid && !s2_valid) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            w_enable <= 1'b1;
            result   <= acc;
          end else if (drain_cnt != 2'd2) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
